// File: rtl/agc_gain_sequencer.sv
//------------------------------------------------------------------------------
// Module   : agc_gain_sequencer
// Purpose  : Closed-loop AGC for a 3-bit VGA driven from 8-bit ADC peak windows.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module agc_gain_sequencer #(
  parameter int unsigned WIN_LEN    = 100,
  parameter int unsigned HIGH_TH    = 96,
  parameter int unsigned LOW_TH     = 32,
  parameter int unsigned CLIP_TH    = 124,
  parameter int unsigned CLIP_HITS  = 4,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned LOCK_WINS  = 3,
  parameter int unsigned INIT_GAIN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] digital_in,
  input  logic       sample_valid,
  input  logic       enable,
  input  logic       man_en,
  input  logic [2:0] man_gain,
  output logic [2:0] vga_control,
  output logic       gain_upd,
  output logic       locked,
  output logic       at_limit
);

  localparam logic [7:0] c_WIN_LEN    = 8'(WIN_LEN);
  localparam logic [7:0] c_HIGH_TH    = 8'(HIGH_TH);
  localparam logic [7:0] c_LOW_TH     = 8'(LOW_TH);
  localparam logic [7:0] c_CLIP_TH    = 8'(CLIP_TH);
  localparam logic [7:0] c_CLIP_HITS  = 8'(CLIP_HITS);
  localparam logic [7:0] c_SETTLE_END = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] c_LOCK_WINS  = 8'(LOCK_WINS);
  localparam logic [2:0] c_INIT_GAIN  = 3'(INIT_GAIN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_ADJUST  = 2'd2,
    ST_SETTLE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       gain_upd_q;
  logic       locked_q, locked_d;
  logic       at_limit_q, at_limit_d;
  logic [7:0] peak_q, peak_d;
  logic [7:0] win_cnt_q, win_cnt_d;
  logic [7:0] clip_cnt_q, clip_cnt_d;
  logic       abort_q, abort_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [7:0] settle_cnt_q, settle_cnt_d;

  logic [7:0] w_mag;
  logic [7:0] w_peak_next;
  logic [7:0] w_clip_next;
  logic [7:0] w_win_next;
  logic [7:0] w_lock_inc;
  logic [2:0] w_adj_code;
  logic       w_adj_lim;

  // Offset-binary magnitude; input 0 would give 128, clamp to 127.
  always_comb begin
    if (digital_in[7]) begin
      w_mag = digital_in - 8'd128;
    end else if (digital_in == 8'd0) begin
      w_mag = 8'd127;
    end else begin
      w_mag = 8'd128 - digital_in;
    end
  end

  assign w_peak_next = (w_mag > peak_q) ? w_mag : peak_q;
  assign w_clip_next = (w_mag >= c_CLIP_TH) ? (clip_cnt_q + 8'd1) : 8'd0;
  assign w_win_next  = win_cnt_q + 8'd1;
  assign w_lock_inc  = (lock_cnt_q >= c_LOCK_WINS) ? lock_cnt_q : (lock_cnt_q + 8'd1);

  // An aborted window is treated as an over-range peak.
  always_comb begin
    w_adj_code = code_q;
    w_adj_lim  = 1'b0;
    if (abort_q || (peak_q >= c_HIGH_TH)) begin
      if (code_q != 3'd7) w_adj_code = code_q + 3'd1;
      else                w_adj_lim  = 1'b1;
    end else if (peak_q < c_LOW_TH) begin
      if (code_q != 3'd0) w_adj_code = code_q - 3'd1;
      else                w_adj_lim  = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    locked_d     = locked_q;
    at_limit_d   = at_limit_q;
    peak_d       = peak_q;
    win_cnt_d    = win_cnt_q;
    clip_cnt_d   = clip_cnt_q;
    abort_d      = abort_q;
    lock_cnt_d   = lock_cnt_q;
    settle_cnt_d = settle_cnt_q;

    if (man_en || !enable) begin
      state_d    = ST_IDLE;
      locked_d   = 1'b0;
      lock_cnt_d = 8'd0;
      if ((state_q == ST_IDLE) && man_en) code_d = man_gain;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_MEASURE;
          peak_d     = 8'd0;
          win_cnt_d  = 8'd0;
          clip_cnt_d = 8'd0;
          abort_d    = 1'b0;
        end
        ST_MEASURE: begin
          if (sample_valid) begin
            peak_d     = w_peak_next;
            win_cnt_d  = w_win_next;
            clip_cnt_d = w_clip_next;
            if (w_clip_next == c_CLIP_HITS) begin
              abort_d = 1'b1;
              state_d = ST_ADJUST;
            end else if (w_win_next == c_WIN_LEN) begin
              state_d = ST_ADJUST;
            end
          end
        end
        ST_ADJUST: begin
          code_d     = w_adj_code;
          at_limit_d = w_adj_lim;
          peak_d     = 8'd0;
          win_cnt_d  = 8'd0;
          clip_cnt_d = 8'd0;
          abort_d    = 1'b0;
          if (w_adj_code != code_q) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = 8'd0;
            lock_cnt_d   = 8'd0;
            locked_d     = 1'b0;
          end else begin
            state_d    = ST_MEASURE;
            lock_cnt_d = w_lock_inc;
            if (w_lock_inc >= c_LOCK_WINS) locked_d = 1'b1;
          end
        end
        ST_SETTLE: begin
          peak_d     = 8'd0;
          win_cnt_d  = 8'd0;
          clip_cnt_d = 8'd0;
          abort_d    = 1'b0;
          if (settle_cnt_q == c_SETTLE_END) begin
            state_d = ST_MEASURE;
          end else begin
            settle_cnt_d = settle_cnt_q + 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      code_q       <= c_INIT_GAIN;
      gain_upd_q   <= 1'b0;
      locked_q     <= 1'b0;
      at_limit_q   <= 1'b0;
      peak_q       <= 8'd0;
      win_cnt_q    <= 8'd0;
      clip_cnt_q   <= 8'd0;
      abort_q      <= 1'b0;
      lock_cnt_q   <= 8'd0;
      settle_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      gain_upd_q   <= (code_d != code_q);
      locked_q     <= locked_d;
      at_limit_q   <= at_limit_d;
      peak_q       <= peak_d;
      win_cnt_q    <= win_cnt_d;
      clip_cnt_q   <= clip_cnt_d;
      abort_q      <= abort_d;
      lock_cnt_q   <= lock_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign vga_control = code_q;
  assign gain_upd    = gain_upd_q;
  assign locked      = locked_q;
  assign at_limit    = at_limit_q;

endmodule

`default_nettype wire
